kt_gen_seq: RTL and testbench

//   Parametrised tag-key (Kt) sequencer. Keeps a Galois LFSR key source.
//   Per request it derives one AES key from the LFSR and drives an external
//   AES core through its Krdy/Kvld/Drdy/Dvld/BSY handshake. It emits TAG_CNT

---
 rtl/kt_gen_seq_if.sv | 47 ++++
 rtl/kt_gen_seq.sv | 196 +++++++++++++++++++
 tb/tb_kt_gen_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kt_gen_seq_if.sv
// Bus bundle for the tag-key sequencer: seed/request inputs, AES core handshake
// and the kt valid/ready stream. "master" is the sequencer side.
interface kt_gen_seq_if #(
    parameter int W     = 128,
    parameter int IDX_W = 2
);
    logic             seed_dv;
    logic [W-1:0]     seed_data;
    logic             start;
    logic [W-1:0]     pt_data;

    logic [W-1:0]     aes_key;
    logic             aes_krdy;
    logic             aes_kvld;
    logic [W-1:0]     aes_din;
    logic             aes_drdy;
    logic [W-1:0]     aes_dout;
    logic             aes_dvld;
    logic             aes_bsy;

    logic [W-1:0]     kt;
    logic             kt_vld;
    logic             kt_rdy;
    logic [IDX_W-1:0] kt_idx;

    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  seed_dv, seed_data, start, pt_data,
        output aes_key, aes_krdy, aes_din, aes_drdy,
        input  aes_kvld, aes_dout, aes_dvld, aes_bsy,
        output kt, kt_vld, kt_idx,
        input  kt_rdy,
        output busy, done, err
    );

    modport slave (
        output seed_dv, seed_data, start, pt_data,
        input  aes_key, aes_krdy, aes_din, aes_drdy,
        output aes_kvld, aes_dout, aes_dvld, aes_bsy,
        input  kt, kt_vld, kt_idx,
        output kt_rdy,
        input  busy, done, err
    );
endinterface

// File: rtl/kt_gen_seq.sv
// Tag-key sequencer: advances a Galois LFSR per request, loads the result as an
// AES key, then streams TAG_CNT tags Kt[i] = AES(K, pt ^ i) to the consumer.
module kt_gen_seq #(
    parameter int           W        = 128,
    parameter logic [W-1:0] POLY     = W'('h87),
    parameter int           LFSR_ADV = 1,
    parameter int           TAG_CNT  = 4,
    parameter int           IDX_W    = (TAG_CNT > 1) ? $clog2(TAG_CNT) : 1
) (
    input logic          clk,
    input logic          RST,
    kt_gen_seq_if.master bus
);

    localparam int CNT_W = (LFSR_ADV > 1) ? $clog2(LFSR_ADV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADV,
        S_KEY,
        S_WAIT_K,
        S_DATA,
        S_WAIT_D,
        S_OUT
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     lfsr_q, lfsr_d;
    logic             seeded_q, seeded_d;
    logic [W-1:0]     pt_q, pt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W-1:0]     aes_key_q, aes_key_d;
    logic             aes_krdy_q, aes_krdy_d;
    logic [W-1:0]     aes_din_q, aes_din_d;
    logic             aes_drdy_q, aes_drdy_d;
    logic [W-1:0]     kt_q, kt_d;
    logic             kt_vld_q, kt_vld_d;
    logic [IDX_W-1:0] kt_idx_q, kt_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
        return {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch; strobes default to 0.
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        seeded_d   = seeded_q;
        pt_d       = pt_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        aes_key_d  = aes_key_q;
        aes_krdy_d = 1'b0;
        aes_din_d  = aes_din_q;
        aes_drdy_d = 1'b0;
        kt_d       = kt_q;
        kt_vld_d   = kt_vld_q;
        kt_idx_d   = kt_idx_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A seed strobe takes priority and swallows a simultaneous start.
                if (bus.seed_dv) begin
                    if (bus.seed_data != '0) begin
                        lfsr_d   = bus.seed_data;
                        seeded_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.start) begin
                    if (seeded_q) begin
                        pt_d    = bus.pt_data;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = S_ADV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_ADV: begin
                lfsr_d = lfsr_step(lfsr_q);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LFSR_ADV - 1)) state_d = S_KEY;
            end

            S_KEY: begin
                if (!bus.aes_bsy) begin
                    aes_key_d  = lfsr_q;
                    aes_krdy_d = 1'b1;
                    state_d    = S_WAIT_K;
                end
            end

            S_WAIT_K: begin
                if (bus.aes_kvld) state_d = S_DATA;
            end

            S_DATA: begin
                if (!bus.aes_bsy) begin
                    aes_din_d  = pt_q ^ {{(W-IDX_W){1'b0}}, idx_q};
                    aes_drdy_d = 1'b1;
                    state_d    = S_WAIT_D;
                end
            end

            S_WAIT_D: begin
                if (bus.aes_dvld) begin
                    kt_d     = bus.aes_dout;
                    kt_idx_d = idx_q;
                    kt_vld_d = 1'b1;
                    state_d  = S_OUT;
                end
            end

            S_OUT: begin
                if (bus.kt_rdy) begin
                    kt_vld_d = 1'b0;
                    if (idx_q == IDX_W'(TAG_CNT - 1)) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_DATA;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q    <= S_IDLE;
            lfsr_q     <= '0;
            seeded_q   <= 1'b0;
            pt_q       <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            aes_key_q  <= '0;
            aes_krdy_q <= 1'b0;
            aes_din_q  <= '0;
            aes_drdy_q <= 1'b0;
            kt_q       <= '0;
            kt_vld_q   <= 1'b0;
            kt_idx_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seeded_q   <= seeded_d;
            pt_q       <= pt_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            aes_key_q  <= aes_key_d;
            aes_krdy_q <= aes_krdy_d;
            aes_din_q  <= aes_din_d;
            aes_drdy_q <= aes_drdy_d;
            kt_q       <= kt_d;
            kt_vld_q   <= kt_vld_d;
            kt_idx_q   <= kt_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.aes_key  = aes_key_q;
    assign bus.aes_krdy = aes_krdy_q;
    assign bus.aes_din  = aes_din_q;
    assign bus.aes_drdy = aes_drdy_q;
    assign bus.kt       = kt_q;
    assign bus.kt_vld   = kt_vld_q;
    assign bus.kt_idx   = kt_idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_kt_gen_seq.sv
// Randomized bench for kt_gen_seq: an AES stand-in (ciphertext = din ^ key)
// and a reference key/tag model derived from the LFSR and tag rules.
module tb_kt_gen_seq;

    localparam int           W        = 128;
    localparam logic [W-1:0] POLY     = W'('h87);
    localparam int           LFSR_ADV = 1;
    localparam int           TAG_CNT  = 4;
    localparam int           IDX_W    = (TAG_CNT > 1) ? $clog2(TAG_CNT) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kt_gen_seq_if #(.W(W), .IDX_W(IDX_W)) bus ();

    kt_gen_seq #(
        .W(W), .POLY(POLY), .LFSR_ADV(LFSR_ADV), .TAG_CNT(TAG_CNT), .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .RST(rst),
        .bus(bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // Reference LFSR contents as the next request will find them.
    logic [W-1:0] lfsr_m = '0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
        logic [W-1:0] shifted;
        shifted = s << 1;
        if (s[W-1]) shifted = shifted ^ POLY;
        return shifted;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_seed(input logic [W-1:0] v);
        bus.seed_dv   = 1'b1;
        bus.seed_data = v;
        tick();
        bus.seed_dv = 1'b0;
        check("seed_err", W'(bus.err), W'(v == '0));
        if (v != '0) lfsr_m = v;
    endtask

    task automatic start_expect_err(input string tag);
        bus.start   = 1'b1;
        bus.pt_data = rand_word();
        tick();
        bus.start = 1'b0;
        check(tag, W'({bus.err, bus.busy}), W'(2'b10));
        tick();
        check({tag, "_pulse"}, W'({bus.err, bus.busy}), W'(2'b00));
    endtask

    // One full request. hold: ticks aes_bsy stays high after start;
    // stall_idx: tag held back 10 cycles by kt_rdy=0; spur: inject an
    // out-of-state aes_dvld plus seed/start while waiting for the key;
    // abort_waitd: return with the design parked in WAIT_D of tag 0.
    task automatic run_request(input logic [W-1:0] pt, input int hold, input int stall_idx,
                               input bit spur, input bit abort_waitd);
        logic [W-1:0] key_e, kt_e;
        int t, exp_t, gap, stall;
        bit seen;

        for (int s = 0; s < LFSR_ADV; s++) lfsr_m = model_step(lfsr_m);
        key_e = lfsr_m;

        bus.start   = 1'b1;
        bus.pt_data = pt;
        bus.aes_bsy = (hold > 0);
        t    = 0;
        seen = 1'b0;
        while (!seen && t < 40) begin
            tick();
            t++;
            bus.start   = 1'b0;
            bus.pt_data = rand_word();
            if (t == 1) check("busy_rise", W'(bus.busy), W'(1));
            if (bus.aes_krdy) seen = 1'b1;
            if (t >= hold) bus.aes_bsy = 1'b0;
        end
        bus.aes_bsy = 1'b0;
        // start is sampled on the first edge; the key strobe follows
        // LFSR_ADV+1 edges later, or one edge after aes_bsy drops.
        exp_t = (hold + 1 > LFSR_ADV + 2) ? hold + 1 : LFSR_ADV + 2;
        check("krdy_lat", W'(t), W'(exp_t));
        check("aes_key", bus.aes_key, key_e);

        tick();
        check("krdy_pulse", W'({bus.aes_krdy, bus.aes_drdy}), W'(0));

        if (spur) begin
            bus.aes_dvld  = 1'b1;
            bus.aes_dout  = rand_word();
            bus.seed_dv   = 1'b1;
            bus.seed_data = rand_word();
            bus.start     = 1'b1;
            tick();
            bus.aes_dvld = 1'b0;
            bus.seed_dv  = 1'b0;
            bus.start    = 1'b0;
            check("spur_ignored", W'({bus.kt_vld, bus.aes_drdy, bus.err}), W'(0));
        end

        gap = $urandom_range(0, 2);
        repeat (gap) begin
            tick();
            check("drdy_early", W'(bus.aes_drdy), W'(0));
        end
        bus.aes_kvld = 1'b1;
        tick();
        bus.aes_kvld = 1'b0;
        check("drdy_wait", W'(bus.aes_drdy), W'(0));
        tick();
        check("drdy_lat", W'(bus.aes_drdy), W'(1));

        for (int i = 0; i < TAG_CNT; i++) begin
            kt_e = key_e ^ pt ^ W'(i);
            check("aes_din", bus.aes_din, pt ^ W'(i));
            if (abort_waitd) return;

            gap = $urandom_range(0, 3);
            tick();
            check("drdy_pulse", W'(bus.aes_drdy), W'(0));
            repeat (gap) begin
                tick();
                check("kt_vld_early", W'(bus.kt_vld), W'(0));
            end
            // AES stand-in answers with din ^ key.
            bus.aes_dvld = 1'b1;
            bus.aes_dout = bus.aes_din ^ bus.aes_key;
            tick();
            bus.aes_dvld = 1'b0;
            bus.aes_dout = rand_word();
            check("kt", bus.kt, kt_e);
            check("kt_ctl", W'({bus.kt_vld, bus.kt_idx}), W'({1'b1, IDX_W'(i)}));

            stall = (i == stall_idx) ? 10 : $urandom_range(0, 2);
            bus.kt_rdy = 1'b0;
            repeat (stall) begin
                tick();
                check("stall_kt", bus.kt, kt_e);
                check("stall_ctl", W'({bus.kt_vld, bus.aes_drdy, bus.kt_idx}),
                      W'({1'b1, 1'b0, IDX_W'(i)}));
            end
            bus.kt_rdy = 1'b1;
            tick();
            bus.kt_rdy = 1'b0;
            check("vld_drop", W'(bus.kt_vld), W'(0));
            check("done", W'(bus.done), W'(i == TAG_CNT - 1));
            if (i == TAG_CNT - 1) begin
                check("busy_end", W'(bus.busy), W'(0));
                tick();
                check("done_pulse", W'({bus.done, bus.busy}), W'(0));
            end else begin
                tick();
                check("drdy_next", W'(bus.aes_drdy), W'(1));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, W'({bus.aes_krdy, bus.aes_drdy, bus.kt_vld, bus.kt_idx,
                                 bus.busy, bus.done, bus.err}), W'(0));
        check({tag, "_key"}, bus.aes_key, '0);
        check({tag, "_din"}, bus.aes_din, '0);
        check({tag, "_kt"}, bus.kt, '0);
    endtask

    initial begin
        logic [W-1:0] v;

        bus.seed_dv   = 1'b0;
        bus.seed_data = '0;
        bus.start     = 1'b0;
        bus.pt_data   = '0;
        bus.aes_kvld  = 1'b0;
        bus.aes_dout  = '0;
        bus.aes_dvld  = 1'b0;
        bus.aes_bsy   = 1'b0;
        bus.kt_rdy    = 1'b0;

        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        start_expect_err("err_unseeded");
        do_seed('0);
        start_expect_err("err_after_zero_seed");

        // seed 1, pt 0: key 2, tags 2,3,0,1; tag 1 stalled for 10 cycles
        do_seed(W'(1));
        run_request('0, 0, 1, 1'b0, 1'b0);
        check("t2_key_held", bus.aes_key, W'(2));

        // top bit set: feedback wraps into the POLY taps
        do_seed({1'b1, {(W-1){1'b0}}});
        run_request(rand_word(), 0, -1, 1'b0, 1'b0);
        check("t3_key_held", bus.aes_key, W'('h87));

        // aes_bsy high for 5 KEY cycles plus a spurious aes_dvld in WAIT_K
        run_request(rand_word(), LFSR_ADV + 6, -1, 1'b1, 1'b0);

        // seed and start together: seed loads, start is dropped
        v = rand_word();
        if (v == '0) v = W'(1);
        bus.seed_dv   = 1'b1;
        bus.seed_data = v;
        bus.start     = 1'b1;
        tick();
        bus.seed_dv = 1'b0;
        bus.start   = 1'b0;
        lfsr_m      = v;
        check("seed_start_err", W'({bus.err, bus.busy}), W'(0));
        tick();
        check("seed_start_idle", W'({bus.busy, bus.aes_krdy}), W'(0));

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                v = rand_word();
                if (v == '0) v = W'(1);
                do_seed(v);
            end
            run_request(rand_word(), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 8)),
                        -1, 1'($urandom_range(0, 1)), 1'b0);
        end

        // asynchronous reset while waiting on aes_dvld
        run_request(rand_word(), 0, -1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick();
        rst    = 1'b0;
        lfsr_m = '0;
        tick();
        check_all_zero("rst_after");
        start_expect_err("err_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
